// File: rtl/rx_i2s.sv
// rx_i2s: I2S receiver oversampled on clk_i.
// Deserialises left/right words and emits them as MSB-first bytes.
`ifndef BIT_DEPTH_16
`define BIT_DEPTH_16 2'd0
`endif
`ifndef BIT_DEPTH_24
`define BIT_DEPTH_24 2'd1
`endif
`ifndef BIT_DEPTH_DOP
`define BIT_DEPTH_DOP 2'd2
`endif
`ifndef BIT_DEPTH_32
`define BIT_DEPTH_32 2'd3
`endif

module rx_i2s #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic [1:0] bit_depth_i,
  input  logic       bclk_i,
  input  logic       lrck_i,
  input  logic       sdata_i,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  input  logic       rd_ready_i,
  output logic       rd_right_o,
  output logic       rd_last_o,
  output logic       streaming_o,
  output logic       overflow_o,
  output logic       frame_err_o
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ALIGN,
    RECEIVE
  } state_e;

  state_e state_q, state_d;

  logic [NS-1:0] bclk_sy;
  logic [NS-1:0] lrck_sy;
  logic [NS-1:0] sdat_sy;
  logic          bclk_d;
  logic          lr_prev_q;
  logic          bclk_s;
  logic          lrck_s;
  logic          sdat_s;
  logic          rise;
  logic          boundary;

  logic [2:0]  dep_b_q;
  logic [2:0]  dep_b_d;
  logic [5:0]  depth;
  logic [5:0]  cnt_q;
  logic [5:0]  cnt_inc;
  logic [31:0] sh_q;
  logic [31:0] sh_shift;
  logic [31:0] word_lj;
  logic        word_done;
  logic        word_err;

  logic [31:0] ser_word;
  logic [2:0]  ser_cnt;
  logic        ser_right;
  logic        fire;
  logic        load;
  logic        ovf_q;
  logic        ferr_q;

  assign bclk_s   = bclk_sy[NS-1];
  assign lrck_s   = lrck_sy[NS-1];
  assign sdat_s   = sdat_sy[NS-1];
  assign rise     = bclk_s & ~bclk_d;
  assign boundary = rise & (lrck_s != lr_prev_q);
  assign depth    = {dep_b_q, 3'b000};

  // Synchronise the async pins and track lrck at each bclk rise.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bclk_sy   <= '0;
      lrck_sy   <= '0;
      sdat_sy   <= '0;
      bclk_d    <= 1'b0;
      lr_prev_q <= 1'b0;
    end else begin
      bclk_sy <= {bclk_sy[NS-2:0], bclk_i};
      lrck_sy <= {lrck_sy[NS-2:0], lrck_i};
      sdat_sy <= {sdat_sy[NS-2:0], sdata_i};
      bclk_d  <= bclk_s;
      if (rise) begin
        lr_prev_q <= lrck_s;
      end
    end
  end

  // Decode the requested depth into bytes per sample.
  always_comb begin
    dep_b_d = 3'd2;
    unique case (bit_depth_i)
      `BIT_DEPTH_16:  dep_b_d = 3'd2;
      `BIT_DEPTH_24:  dep_b_d = 3'd3;
      `BIT_DEPTH_DOP: dep_b_d = 3'd3;
      `BIT_DEPTH_32:  dep_b_d = 3'd4;
    endcase
  end

  // Shift candidate and MSB-justified word for handoff.
  always_comb begin
    cnt_inc  = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
    sh_shift = (cnt_q < depth) ? {sh_q[30:0], sdat_s} : sh_q;
    word_lj  = sh_shift;
    unique case (dep_b_q)
      3'd2:    word_lj = {sh_shift[15:0], 16'h0000};
      3'd3:    word_lj = {sh_shift[23:0], 8'h00};
      default: word_lj = sh_shift;
    endcase
  end

  // Next-state logic and word completion / framing checks.
  always_comb begin
    state_d   = state_q;
    word_done = 1'b0;
    word_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) state_d = WAIT_ALIGN;
      end
      WAIT_ALIGN: begin
        if (boundary && !lrck_s) state_d = RECEIVE;
      end
      RECEIVE: begin
        if (boundary) begin
          if (cnt_inc >= depth) word_done = 1'b1;
          else                  word_err  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en_i) begin
      state_d   = IDLE;
      word_done = 1'b0;
      word_err  = 1'b0;
    end
  end

  // State register and depth latch on IDLE exit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      dep_b_q <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && en_i) begin
        dep_b_q <= dep_b_d;
      end
    end
  end

  // Deserialiser: shift bits in, clear at each boundary.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (state_q != RECEIVE || !en_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (rise) begin
      if (boundary) begin
        cnt_q <= '0;
        sh_q  <= '0;
      end else begin
        cnt_q <= cnt_inc;
        sh_q  <= sh_shift;
      end
    end
  end

  assign fire = rd_valid_o & rd_ready_i;
  assign load = word_done &
                ((ser_cnt == 3'd0) | (fire & (ser_cnt == 3'd1)));

  // Serialiser: one held word, emitted a byte per handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ser_word  <= '0;
      ser_cnt   <= '0;
      ser_right <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (!en_i) begin
      ser_word  <= '0;
      ser_cnt   <= '0;
      ser_right <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (load) begin
        ser_word  <= word_lj;
        ser_cnt   <= dep_b_q;
        ser_right <= lr_prev_q;
      end else if (fire) begin
        ser_word <= {ser_word[23:0], 8'h00};
        ser_cnt  <= ser_cnt - 3'd1;
      end
      ovf_q  <= word_done & ~load;
      ferr_q <= word_err;
    end
  end

  assign rd_data_o   = ser_word[31:24];
  assign rd_valid_o  = (ser_cnt != 3'd0);
  assign rd_last_o   = (ser_cnt == 3'd1);
  assign rd_right_o  = ser_right;
  assign streaming_o = (state_q == RECEIVE);
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_rx_i2s.sv
// tb_rx_i2s: scoreboard bench for rx_i2s.
// Drives I2S frames and compares emitted bytes against a queue.
module tb_rx_i2s;

  localparam logic [1:0] D16  = 2'd0;
  localparam logic [1:0] D24  = 2'd1;
  localparam logic [1:0] DDOP = 2'd2;
  localparam logic [1:0] D32  = 2'd3;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       en_i = 1'b0;
  logic [1:0] bit_depth_i = 2'd0;
  logic       bclk_i = 1'b0;
  logic       lrck_i = 1'b0;
  logic       sdata_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       rd_ready_i = 1'b1;
  logic       rd_right_o;
  logic       rd_last_o;
  logic       streaming_o;
  logic       overflow_o;
  logic       frame_err_o;

  int checks = 0;
  int errors = 0;
  int rmode = 0;
  int ovf_cnt = 0;
  int ferr_cnt = 0;
  logic prev_bit = 1'b0;
  logic [9:0] exp_q[$];
  logic stall_q = 1'b0;
  logic [9:0] stall_v = '0;

  rx_i2s #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .en_i(en_i),
    .bit_depth_i(bit_depth_i),
    .bclk_i(bclk_i),
    .lrck_i(lrck_i),
    .sdata_i(sdata_i),
    .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i),
    .rd_right_o(rd_right_o),
    .rd_last_o(rd_last_o),
    .streaming_o(streaming_o),
    .overflow_o(overflow_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    case (rmode)
      1:       rd_ready_i = ~rd_ready_i;
      2:       rd_ready_i = 1'b0;
      default: rd_ready_i = 1'b1;
    endcase
  end

  always @(negedge clk_i) begin
    if (overflow_o)  ovf_cnt++;
    if (frame_err_o) ferr_cnt++;
  end

  always @(negedge clk_i) begin
    logic [9:0] obs;
    logic [9:0] e;
    obs = {rd_right_o, rd_last_o, rd_data_o};
    if (reset_n_i && rd_valid_o) begin
      if (stall_q) begin
        checks++;
        if (obs !== stall_v) begin
          errors++;
          $display("FAIL hold: got %h required %h", obs, stall_v);
        end
      end
      if (rd_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte: got %h required none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL byte: got %h required %h", obs, e);
          end
        end
      end
    end
    stall_q = reset_n_i && rd_valid_o && !rd_ready_i;
    stall_v = obs;
  end

  task automatic send_word(input bit ch, input logic [31:0] v,
                           input int bpw);
    for (int k = 0; k < bpw; k++) begin
      bclk_i = 1'b0;
      lrck_i = ch;
      sdata_i = (k == 0) ? prev_bit : v[32-k];
      #40;
      bclk_i = 1'b1;
      #40;
    end
    prev_bit = v[32-bpw];
  endtask

  task automatic push_word(input bit r, input logic [31:0] v,
                           input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({r, (i == n - 1), v[31-8*i -: 8]});
  endtask

  task automatic restart(input logic [1:0] d);
    en_i = 1'b0;
    repeat (4) @(posedge clk_i);
    bit_depth_i = d;
    en_i = 1'b1;
    repeat (4) @(posedge clk_i);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk_i);
      n++;
    end
    repeat (20) @(posedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: left %0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({rd_data_o, rd_valid_o, rd_right_o, rd_last_o} !== 11'h0) begin
      errors++;
      $display("FAIL reset out: got %h required 0",
               {rd_data_o, rd_valid_o, rd_right_o, rd_last_o});
    end
    checks++;
    if ({streaming_o, overflow_o, frame_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset flags: got %b required 000",
               {streaming_o, overflow_o, frame_err_o});
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    checks++;
    if ({rd_valid_o, streaming_o} !== 2'b00) begin
      errors++;
      $display("FAIL idle: got %b required 00", {rd_valid_o, streaming_o});
    end
  endtask

  task automatic test_16;
    rmode = 0;
    restart(D16);
    push_word(1'b0, 32'h12340000, 2);
    push_word(1'b1, 32'hABCD0000, 2);
    send_word(1'b1, 32'h5A5A0000, 16);
    send_word(1'b0, 32'h12340000, 16);
    #1;
    checks++;
    if (streaming_o !== 1'b1) begin
      errors++;
      $display("FAIL stream16: got %b required 1", streaming_o);
    end
    send_word(1'b1, 32'hABCD0000, 16);
    send_word(1'b0, 32'h0, 1);
    wait_drain("d16");
    en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({rd_valid_o, streaming_o} !== 2'b00) begin
      errors++;
      $display("FAIL disable: got %b required 00", {rd_valid_o, streaming_o});
    end
  endtask

  task automatic test_24_stall;
    rmode = 1;
    restart(D24);
    push_word(1'b0, 32'h80000100, 3);
    push_word(1'b1, 32'h7FFFFE00, 3);
    send_word(1'b1, 32'h33333300, 24);
    send_word(1'b0, 32'h80000100, 24);
    send_word(1'b1, 32'h7FFFFE00, 24);
    send_word(1'b0, 32'h0, 1);
    wait_drain("d24");
    rmode = 0;
  endtask

  task automatic test_32;
    rmode = 0;
    restart(D32);
    push_word(1'b0, 32'hDEADBEEF, 4);
    push_word(1'b1, 32'h0BADF00D, 4);
    send_word(1'b1, 32'h11111111, 32);
    send_word(1'b0, 32'hDEADBEEF, 32);
    send_word(1'b1, 32'h0BADF00D, 32);
    send_word(1'b0, 32'h0, 1);
    wait_drain("d32");
    restart(D16);
    push_word(1'b0, 32'hCAFE0000, 2);
    push_word(1'b1, 32'h5A5A0000, 2);
    send_word(1'b1, 32'h77777777, 32);
    send_word(1'b0, 32'hCAFE1234, 32);
    send_word(1'b1, 32'h5A5AFFFF, 32);
    send_word(1'b0, 32'h0, 1);
    wait_drain("d16w32");
  endtask

  task automatic test_mid_right;
    rmode = 0;
    en_i = 1'b0;
    bit_depth_i = DDOP;
    repeat (4) @(posedge clk_i);
    fork
      send_word(1'b1, 32'hA5A5A500, 24);
      begin
        repeat (40) @(posedge clk_i);
        en_i = 1'b1;
      end
    join
    checks++;
    if (exp_q.size() != 0 || streaming_o !== 1'b0) begin
      errors++;
      $display("FAIL align: got stream %b required 0", streaming_o);
    end
    push_word(1'b0, 32'h12345600, 3);
    push_word(1'b1, 32'h789ABC00, 3);
    send_word(1'b0, 32'h12345600, 24);
    send_word(1'b1, 32'h789ABC00, 24);
    send_word(1'b0, 32'h0, 1);
    wait_drain("mid");
  endtask

  task automatic test_overflow;
    rmode = 2;
    restart(D16);
    ovf_cnt = 0;
    push_word(1'b0, 32'h11220000, 2);
    send_word(1'b1, 32'h99990000, 16);
    send_word(1'b0, 32'h11220000, 16);
    send_word(1'b1, 32'h33440000, 16);
    send_word(1'b0, 32'h0, 1);
    repeat (20) @(posedge clk_i);
    #1;
    checks++;
    if ({rd_valid_o, rd_data_o} !== 9'h111) begin
      errors++;
      $display("FAIL held: got %h required 111", {rd_valid_o, rd_data_o});
    end
    checks++;
    if (ovf_cnt != 1) begin
      errors++;
      $display("FAIL ovf: got %0d required 1", ovf_cnt);
    end
    rmode = 0;
    wait_drain("ovf");
    repeat (50) @(posedge clk_i);
  endtask

  task automatic test_frame_err;
    rmode = 0;
    restart(D16);
    ferr_cnt = 0;
    ovf_cnt = 0;
    send_word(1'b1, 32'h12340000, 16);
    send_word(1'b0, 32'hFFC00000, 10);
    send_word(1'b1, 32'h0, 1);
    repeat (20) @(posedge clk_i);
    checks++;
    if (ferr_cnt != 1) begin
      errors++;
      $display("FAIL ferr: got %0d required 1", ferr_cnt);
    end
    checks++;
    if (ovf_cnt != 0 || rd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ferr out: got ovf %0d valid %b required 0 0",
               ovf_cnt, rd_valid_o);
    end
  endtask

  task automatic test_reset_mid;
    rmode = 2;
    restart(D16);
    send_word(1'b1, 32'h0, 16);
    send_word(1'b0, 32'h43210000, 16);
    fork
      send_word(1'b1, 32'h87650000, 16);
      begin
        repeat (60) @(posedge clk_i);
        #2;
        checks++;
        if ({rd_valid_o, rd_data_o} !== 9'h143) begin
          errors++;
          $display("FAIL pre-rst: got %h required 143",
                   {rd_valid_o, rd_data_o});
        end
        reset_n_i = 1'b0;
        #1;
        checks++;
        if ({rd_data_o, rd_valid_o, rd_right_o, rd_last_o,
             streaming_o, overflow_o, frame_err_o} !== 14'h0) begin
          errors++;
          $display("FAIL mid-rst: got %h required 0",
                   {rd_data_o, rd_valid_o, rd_right_o, rd_last_o,
                    streaming_o, overflow_o, frame_err_o});
        end
        repeat (3) @(posedge clk_i);
        reset_n_i = 1'b1;
      end
    join
    rmode = 0;
    push_word(1'b0, 32'h0F0F0000, 2);
    push_word(1'b1, 32'hF0F00000, 2);
    send_word(1'b1, 32'h0, 16);
    send_word(1'b0, 32'h0F0F0000, 16);
    send_word(1'b1, 32'hF0F00000, 16);
    send_word(1'b0, 32'h0, 1);
    wait_drain("rst");
  endtask

  initial begin
    test_reset;
    test_16;
    test_24_stall;
    test_32;
    test_mid_right;
    test_overflow;
    test_frame_err;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
